// File: rtl/mem_lsu_pkg.sv
// Shared types and byte-lane helpers for the load/store unit.
// Size codes, FSM states and the captured request bundle.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       sgn;
    } lsu_req_t;

    function automatic logic [4:0] lane_shift(
        input logic [1:0] off,
        input logic [1:0] size
    );
        if (size == SZ_HALF)
            return {off[1], 4'b0000};
        return {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_mask(
        input logic [1:0] size
    );
        unique case (1'b1)
            size == SZ_BYTE: return 32'h0000_00ff;
            size == SZ_HALF: return 32'h0000_ffff;
            default:         return 32'hffff_ffff;
        endcase
    endfunction

    function automatic logic addr_err(
        input logic [1:0] size,
        input logic [1:0] off
    );
        unique case (1'b1)
            size == SZ_BAD:  return 1'b1;
            size == SZ_HALF: return off[0];
            size == SZ_WORD: return off != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
// master = pipeline MEM stage, slave = mem_lsu.
interface mem_lsu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size,
        output req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid,
        input  rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid,
        output rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lane_unit.sv
// Byte-lane extract (loads) and merge (sub-word stores).
// Pure combinational; shared by the RD and RMW_RD paths.
module mem_lane_unit
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh   = lane_shift(off, size);
        mask = lane_mask(size);
        lane = rdata >> sh;
        ext  = lane;
        unique case (1'b1)
            size == SZ_BYTE:
                ext = {{24{sgn & lane[7]}}, lane[7:0]};
            size == SZ_HALF:
                ext = {{16{sgn & lane[15]}}, lane[15:0]};
            default:
                ext = lane;
        endcase
        merged = (rdata & ~(mask << sh))
               | ((wdata & mask) << sh);
    end
endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the word-wide data memory port.
// Sub-word stores go through a read-modify-write cycle.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_lsu_if.slave          bus,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t      state;
    lsu_req_t    cur;
    logic [31:0] ext;
    logic [31:0] merged;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [1:0]  in_off;
    logic        in_err;

    assign in_off = bus.req_addr[1:0];
    assign in_err = addr_err(bus.req_size, in_off);

    mem_lane_unit u_lane (
        .rdata  (mem_rdata),
        .off    (cur.off),
        .size   (cur.size),
        .sgn    (cur.sgn),
        .wdata  (mem_wdata),
        .ext    (ext),
        .merged (merged)
    );

    // mem_wdata doubles as the held store data for the RMW merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cur.off   <= in_off;
                        cur.size  <= bus.req_size;
                        cur.sgn   <= bus.req_signed;
                        mem_addr  <= bus.req_addr[ADDR_W+1:2];
                        mem_wdata <= bus.req_wdata;
                        if (in_err) begin
                            rsp_err_q <= 1'b1;
                            state     <= RESP;
                        end else if (!bus.req_we) begin
                            state <= RD;
                        end else if (bus.req_size == SZ_WORD) begin
                            state <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata_q <= ext;
                    state       <= RESP;
                end
                RMW_RD: begin
                    mem_wdata <= merged;
                    state     <= WR;
                end
                WR: state <= RESP;
                RESP: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mem_read      = (state == RD) || (state == RMW_RD);
    assign mem_write     = state == WR;
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a byte-array memory model.
// Directed cases first, then random requests with optional chaining.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld = 1'b1;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   ram [256];
    logic [31:0]   model [256];
    int            total = 0;
    int            bad = 0;

    bit        nxt_en = 1'b0;
    bit        nxt_we;
    bit [1:0]  nxt_sz;
    bit        nxt_sg;
    bit [9:0]  nxt_a;
    bit [31:0] nxt_wd;

    mem_lsu_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    mem_lsu #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= 32'(i * 10 + 1);
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(
        input bit [1:0] sz,
        input bit [1:0] off
    );
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return off % 2 == 1;
        if (sz == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(
        input logic [31:0] w,
        input bit [1:0]    off,
        input bit [1:0]    sz,
        input bit          sg
    );
        logic [7:0]  b [4];
        logic [31:0] v;
        int          o;
        o = int'(off);
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (sz == 2'd0) begin
            v = {24'h0, b[o]};
            if (sg && b[o][7]) v = v | 32'hffff_ff00;
        end else if (sz == 2'd1) begin
            v = {16'h0, b[o+1], b[o]};
            if (sg && b[o+1][7]) v = v | 32'hffff_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(
        input logic [31:0] w,
        input bit [1:0]    off,
        input bit [1:0]    sz,
        input logic [31:0] wd
    );
        logic [7:0] b [4];
        int         o;
        o = int'(off);
        if (sz == 2'd2) return wd;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        b[o] = wd[7:0];
        if (sz == 2'd1) b[o+1] = wd[15:8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic settle();
        @(posedge clk); #1;
        check("idle_ready", 32'(bus.req_ready), 1);
        check("idle_vld", 32'(bus.rsp_valid), 0);
        check("idle_rdata", bus.rsp_rdata, 0);
        check("idle_err", 32'(bus.rsp_err), 0);
    endtask

    task automatic run(
        input  bit          we,
        input  bit [1:0]    sz,
        input  bit          sg,
        input  bit [9:0]    a,
        input  bit [31:0]   wd,
        input  int          exp_w,
        output logic [31:0] got
    );
        bit          e;
        int          el;
        int          waits;
        int          c;
        int          lat;
        logic [31:0] old;
        logic [31:0] er;
        logic [31:0] ew;
        logic [7:0]  rm;
        logic [7:0]  wm;
        logic [7:0]  erm;
        logic [7:0]  ewm;
        logic        rdy_bad;
        logic        err_got;
        logic [31:0] rd_got;
        logic [31:0] wd_got;
        logic [AW-1:0] wa_got;
        logic [AW-1:0] a1;
        got = '0;
        e   = ref_err(sz, a[1:0]);
        old = model[a[9:2]];
        el  = e ? 1 : ((!we || sz == 2'd2) ? 2 : 3);
        er  = (e || we) ? 32'h0 : ref_load(old, a[1:0], sz, sg);
        ew  = ref_store(old, a[1:0], sz, wd);
        erm = (!e && (!we || sz != 2'd2)) ? 8'h01 : 8'h00;
        ewm = (e || !we) ? 8'h00
            : (sz == 2'd2 ? 8'h01 : 8'h02);
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        if (exp_w >= 0)
            check("accept_wait", 32'(waits), 32'(exp_w));
        @(posedge clk); #1;
        if (nxt_en) begin
            bus.req_we     = nxt_we;
            bus.req_size   = nxt_sz;
            bus.req_signed = nxt_sg;
            bus.req_addr   = nxt_a;
            bus.req_wdata  = nxt_wd;
        end else begin
            bus.req_valid = 1'b0;
        end
        c = 1; lat = 0; rm = 0; wm = 0; rdy_bad = 0;
        wd_got = '0; wa_got = '0; a1 = '0;
        err_got = 0; rd_got = '0;
        while (c <= 6) begin
            rm[c-1] = mem_read;
            wm[c-1] = mem_write;
            if (bus.req_ready) rdy_bad = 1'b1;
            if (mem_write) begin
                wd_got = mem_wdata;
                wa_got = mem_addr;
            end
            if (c == 1) a1 = mem_addr;
            if (bus.rsp_valid) begin
                lat     = c;
                rd_got  = bus.rsp_rdata;
                err_got = bus.rsp_err;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        if (lat == 0) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", 32'(lat), 32'(el));
        check("rdata", rd_got, er);
        check("err", 32'(err_got), 32'(e));
        check("read_cycles", 32'(rm), 32'(erm));
        check("write_cycles", 32'(wm), 32'(ewm));
        check("ready_busy", 32'(rdy_bad), 0);
        if (!e) check("mem_addr", 32'(a1), 32'(a[9:2]));
        if (!e && we) begin
            check("wr_data", wd_got, ew);
            check("wr_addr", 32'(wa_got), 32'(a[9:2]));
            model[a[9:2]] = ew;
        end
        got = rd_got;
    endtask

    task automatic gen_next();
        nxt_we = 1'($urandom_range(0, 1));
        nxt_sz = 2'($urandom_range(0, 3));
        nxt_sg = 1'($urandom_range(0, 1));
        nxt_a  = 10'($urandom_range(0, 1023));
        nxt_wd = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (nxt_sz == 2'd1) nxt_a[0] = 1'b0;
            if (nxt_sz == 2'd2) nxt_a[1:0] = 2'b00;
        end
    endtask

    initial begin
        logic [31:0] got;
        bit          cw;
        bit [1:0]    cs;
        bit          cg;
        bit [9:0]    ca;
        bit [31:0]   cd;
        bit          pc;
        bit          ch;
        for (int i = 0; i < 256; i++)
            model[i] = 32'(i * 10 + 1);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_vld", 32'(bus.rsp_valid), 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_err", 32'(bus.rsp_err), 0);
        check("rst_rd", 32'(mem_read), 0);
        check("rst_wr", 32'(mem_write), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        ld    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, SZ_WORD, 0, 10'h14, 0, 0, got);
        check("tp_lw14", got, 32'h0000_0033);
        settle();
        run(0, SZ_BYTE, 1, 10'h34, 0, 0, got);
        check("tp_lb34_s", got, 32'hffff_ff83);
        settle();
        run(0, SZ_BYTE, 0, 10'h34, 0, 0, got);
        check("tp_lb34_u", got, 32'h0000_0083);
        settle();
        run(1, SZ_BYTE, 0, 10'h09, 32'hab, 0, got);
        settle();
        run(0, SZ_WORD, 0, 10'h08, 0, 0, got);
        check("tp_rmw_lw08", got, 32'h0000_ab15);
        settle();
        run(0, SZ_HALF, 0, 10'h03, 0, 0, got);
        check("tp_err_half", got, 0);
        settle();
        run(0, SZ_BAD, 0, 10'h10, 0, 0, got);
        check("tp_err_size", got, 0);
        settle();

        nxt_en = 1'b1;
        nxt_we = 1'b0; nxt_sz = SZ_WORD; nxt_sg = 1'b0;
        nxt_a  = 10'h20; nxt_wd = 32'h0;
        run(1, SZ_WORD, 0, 10'h20, 32'hdead_beef, 0, got);
        nxt_en = 1'b0;
        run(0, SZ_WORD, 0, 10'h20, 0, 1, got);
        check("tp_b2b", got, 32'hdead_beef);
        settle();

        bus.req_we     = 1'b1;
        bus.req_size   = SZ_HALF;
        bus.req_signed = 1'b0;
        bus.req_addr   = 10'h0c;
        bus.req_wdata  = 32'h1234_5678;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_rmw_rd", 32'(mem_read), 1);
        rst_n = 1'b0;
        #1;
        check("abort_rd", 32'(mem_read), 0);
        check("abort_wr", 32'(mem_write), 0);
        check("abort_ready", 32'(bus.req_ready), 1);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_wdata", mem_wdata, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", 32'(bus.rsp_valid), 0);
            check("abort_no_wr", 32'(mem_write), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, SZ_WORD, 0, 10'h0c, 0, 0, got);
        check("abort_word3", got, 32'h0000_001f);
        settle();

        pc = 1'b0;
        gen_next();
        cw = nxt_we; cs = nxt_sz; cg = nxt_sg;
        ca = nxt_a; cd = nxt_wd;
        for (int i = 0; i < 300; i++) begin
            gen_next();
            ch = (i != 299) && ($urandom_range(0, 3) == 0);
            nxt_en = ch;
            run(cw, cs, cg, ca, cd, pc ? 1 : 0, got);
            if (!ch) settle();
            pc = ch;
            cw = nxt_we; cs = nxt_sz; cg = nxt_sg;
            ca = nxt_a; cd = nxt_wd;
        end
        nxt_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that drives the word-wide, combinationally-read, level-written memory port. It is the requester side of the data memory interface. It accepts one CPU load or store per handshake with byte, halfword or word size. Sub-word stores are turned into a read-modify-write, and loads are lane-extracted with sign or zero extension. It sits between the pipeline's MEM stage and the data memory.

## Interface
Parameters:
- ADDR_W, 8, memory word-address width; the byte address is ADDR_W+2 bits.
- DATA_W, 32, data width; fixed at 32 for lane logic.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs on an edge where valid&&ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  ADDR_W+2  byte address, little-endian.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe (level).
- mem_addr  out  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid combinationally from mem_addr.

## Operation
- The FSM has five states: IDLE, RD, RMW_RD, WR and RESP. All mem_* and rsp_* outputs are registered or decoded from the state register only; there are no combinational paths from request inputs.
- On accept in IDLE, the block captures addr, size, signed and wdata, then branches:
  - error → RESP with err=1;
  - load → RD;
  - word store → WR with mem_wdata=req_wdata;
  - sub-word store → RMW_RD.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]≠0. On error, mem_read and mem_write never assert.
- RD: mem_read=1. At the end of the cycle, mem_rdata is extracted and registered into rsp_rdata:
  - byte lane addr[1:0] → bits [8k+7:8k];
  - half lane addr[1] → bits [16k+15:16k];
  - result is zero- or sign-extended per req_signed;
  - then → RESP.
- RMW_RD: mem_read=1. At the end of the cycle, mem_rdata is merged with the low byte or half of wdata into the selected lane, registered into mem_wdata, then → WR.
- WR: mem_write=1 for exactly one cycle, then → RESP.
- RESP: rsp_valid=1 for one cycle, then → IDLE. rsp_rdata and rsp_err clear to 0 on exit.
- mem_addr and mem_wdata change only on the accept edge and the RMW_RD→WR edge. They hold their values after mem_write falls, until the next accept.
- Outside RESP, rsp_rdata is 0.

## Timing
- All outputs reset to 0 except req_ready, which is 1 (IDLE).
- Latency is counted in cycles after the accept edge:
  - error: rsp_valid in cycle 1;
  - load and word store: rsp_valid in cycle 2;
  - sub-word store: rsp_valid in cycle 3.
- Throughput: req_ready returns in the cycle after RESP. Back-to-back requests are therefore spaced 3, 3 or 4 cycles apart.
- req_valid while busy is ignored (not accepted). The requester holds its fields stable while valid&&!ready.
- rst_n low mid-operation aborts immediately:
  - mem_write and mem_read drop asynchronously;
  - no response is issued;
  - a partial RMW performs no write.

## Structure
- Package mem_lsu_pkg holds the size codes (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the byte-lane helpers.
- One combinational sub-module, mem_lane_unit, provides extract (rdata, offset, size, signed → value) and merge (old word, wdata, offset, size → new word). It is shared by the RD and RMW_RD paths.

## Test plan
Attach the team memory model; its initial contents are ram[i]=i*10+1.
- Load word at addr 0x14: rsp_valid in cycle 2, rdata=0x00000033, err=0, mem_read high in cycle 1 only.
- Load byte at addr 0x34 (word 13 = 0x83): with signed=1, rdata=0xFFFFFF83; with signed=0, rdata=0x00000083.
- Store byte 0xAB at addr 0x09 (word 2 = 0x15): RMW_RD in cycle 1, WR in cycle 2 with mem_wdata=0x0000AB15, rsp in cycle 3. A following load word at 0x08 returns 0x0000AB15.
- Half load at addr 0x03 and size=11 at addr 0x10: rsp_err=1 in cycle 1, rdata=0, mem_read and mem_write never assert.
- Word store 0xDEADBEEF at 0x20, then immediately a load word at 0x20 (valid held): the second accept occurs in cycle 3 and returns 0xDEADBEEF. req_ready is low in cycles 1–2.
- Assert rst_n low during RMW_RD of a half store at 0x0C: outputs go to reset values at once, no rsp_valid, and word 3 still reads 0x1F.
